mdu_hilo: RTL and testbench

- Iterative multiply/divide unit in the EX stage, next to the ALU.
- Fed by the same forwarded operand pair as the ALU.
- Owns the architectural HI/LO registers; their outputs feed the EX result mux for mfhi/mflo.
- Multi-cycle: raises busy so the hazard unit stalls IF/ID/EX.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mdu_divstep.sv | 24 ++
 rtl/mdu_hilo.sv | 195 +++++++++++++++++++
 tb/tb_mdu_hilo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// op codes, FSM state encodings and the iteration count.
package mips_pkg;

  localparam int unsigned MDU_XLEN = 32;
  localparam int unsigned MDU_ITER = MDU_XLEN;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module mdu_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] shifted;
  logic           ge;

  // Trial subtraction; the shifted remainder may need one extra bit.
  always_comb begin
    shifted = {rem_i, quot_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvsr_i});
    rem_o   = ge ? (shifted[WIDTH-1:0] - dvsr_i) : shifted[WIDTH-1:0];
    quot_o  = {quot_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Operates on magnitudes and applies signs in a final FIX cycle.
// Optional macro MDU_EARLY_OUT_EN: multiply ends as soon as the
// remaining multiplier is zero (divide stays full length).
module mdu_hilo
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned   CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mdu_state_e           state_q, state_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 divz_q, divz_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     step_rem, step_quot;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   prod_fix;
  logic                 op_signed, op_arith, op_div;
  logic                 last_iter, mul_skip;

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quot_o (step_quot)
  );

  // Operand decode and magnitude capture for signed ops.
  always_comb begin
    op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    op_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
    op_arith  = op_div || (op == MDU_MULT) || (op == MDU_MULTU);
    a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
    last_iter = (cnt_q == CNT_LAST);
    prod_fix  = neg_res_q ? -prod_q : prod_q;
  end

`ifdef MDU_EARLY_OUT_EN
  assign mul_skip = (mplier_q == '0);
`else
  assign mul_skip = 1'b0;
`endif

  // Next-state and datapath update for the IDLE/RUN/FIX sequence.
  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvsr_d    = dvsr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    done_d    = 1'b0;

    unique case (state_q)
      MDU_IDLE: begin
        if (start) begin
          if (op_arith) begin
            prod_d    = '0;
            mcand_d   = {{WIDTH{1'b0}}, a_mag};
            mplier_d  = b_mag;
            rem_d     = '0;
            quot_d    = a_mag;
            dvsr_d    = b_mag;
            cnt_d     = '0;
            is_div_d  = op_div;
            neg_res_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = op_signed && a[WIDTH-1];
            divz_d    = (b == '0);
            state_d   = MDU_RUN;
          end else if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end
        end
      end

      MDU_RUN: begin
        if (flush) begin
          state_d = MDU_IDLE;
        end else if (is_div_q) begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + CW'(1);
          if (last_iter) state_d = MDU_FIX;
        end else if (mul_skip) begin
          state_d = MDU_FIX;
        end else begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (last_iter) state_d = MDU_FIX;
        end
      end

      MDU_FIX: begin
        state_d = MDU_IDLE;
        if (!flush) begin
          if (is_div_q) begin
            hi_d = neg_rem_q ? -rem_q : rem_q;
            // Divide by zero reports an all-ones quotient regardless of sign;
            // the remainder path already reproduces the raw dividend.
            lo_d = divz_q ? '1 : (neg_res_q ? -quot_q : quot_q);
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          done_d = 1'b1;
        end
      end

      default: state_d = MDU_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MDU_IDLE;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      dvsr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      dvsr_q    <= dvsr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != MDU_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: scoreboard of expected HI/LO and
// done-cycle values, plus MTHI/MTLO, flush, reset and early-out scenarios.
module tb_mdu_hilo;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  logic [2:0]  tab_op[7] = '{MDU_MULT, MDU_MULTU, MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIV, MDU_MULT};
  logic [31:0] tab_a[7]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFF9, 32'h1234, 32'h80000000, 32'h80000000};
  logic [31:0] tab_b[7]  = '{32'd5, 32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'h80000000};

  mdu_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    int q, m;
    r = '0;
    case (o)
      MDU_MULT:  r = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      MDU_MULTU: r = {32'b0, x} * {32'b0, y};
      MDU_DIV: begin
        if (y == 32'd0) r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else begin
          q = $signed(x) / $signed(y);
          m = $signed(x) % $signed(y);
          r = {m, q};
        end
      end
      MDU_DIVU: begin
        if (y == 32'd0) r = {x, 32'hFFFFFFFF};
        else r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_cycles(input logic [2:0] o, input logic [31:0] y);
    logic [31:0] m;
    int n;
    m = (o == MDU_MULT && y[31]) ? -y : y;
    n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`ifdef MDU_EARLY_OUT_EN
    if (o == MDU_MULT || o == MDU_MULTU) return ((n + 1 > 32) ? 32 : n + 1) + 2;
`endif
    return (n >= 0) ? 34 : 0;
  endfunction

  // Issue one op in the current cycle (cycle 0) and wait for done.
  task automatic drive_and_wait(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input int inj, output logic [31:0] hs, output logic [31:0] ls,
                                output int dc, output int bc, output logic bd);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    dc = -1; bc = 0; bd = 1'b1; hs = hi; ls = lo;
    for (int c = 1; c <= 80; c++) begin
      if (done) begin
        dc = c; bd = busy; hs = hi; ls = lo;
        break;
      end
      if (busy) bc++;
      if (c == inj) begin
        start = 1'b1; op = MDU_DIVU; a = 32'd5; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [63:0] r;
    logic [31:0] hs, ls, x, y;
    logic [2:0]  o;
    int dc, bc;
    logic bd;
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      if (i < 7) begin
        o = tab_op[i]; x = tab_a[i]; y = tab_b[i];
      end else begin
        o = 3'($urandom_range(0, 3));
        x = $urandom;
        y = (i % 2 == 1) ? 32'($urandom_range(0, 300)) : $urandom;
      end
      r = model(o, x, y);
      sb.push_back('{hi: r[63:32], lo: r[31:0], cyc: exp_cycles(o, y)});
      drive_and_wait(o, x, y, 0, hs, ls, dc, bc, bd);
      e = sb.pop_front();
      checks++; if (hs !== e.hi) begin failures++; $display("FAIL arith%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, hs, e.hi); end
      checks++; if (ls !== e.lo) begin failures++; $display("FAIL arith%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, ls, e.lo); end
      checks++; if (dc !== e.cyc) begin failures++; $display("FAIL arith%0d_done_cycle got=%0d exp=%0d", i, dc, e.cyc); end
      checks++; if (bc !== e.cyc - 1 || bd !== 1'b0) begin failures++; $display("FAIL arith%0d_busy got=%0d/%b exp=%0d/0", i, bc, bd, e.cyc - 1); end
    end
  endtask

  task automatic test_mt_back_to_back();
    start = 1'b1; op = MDU_MTHI; a = 32'hAAAA; b = 32'h0;
    @(posedge clk); #1;
    checks++; if (hi !== 32'hAAAA) begin failures++; $display("FAIL mthi_hi got=%h exp=0000aaaa", hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mthi_busy_done got=%b%b exp=00", busy, done); end
    op = MDU_MTLO; a = 32'h5555;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (lo !== 32'h5555) begin failures++; $display("FAIL mtlo_lo got=%h exp=00005555", lo); end
    checks++; if (hi !== 32'hAAAA) begin failures++; $display("FAIL mtlo_hi got=%h exp=0000aaaa", hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mtlo_busy_done got=%b%b exp=00", busy, done); end
  endtask

  task automatic test_start_while_busy();
    logic [63:0] r;
    logic [31:0] hs, ls;
    int dc, bc;
    logic bd;
    exp_t e;
    r = model(MDU_MULT, 32'h00000007, 32'h00000100);
    sb.push_back('{hi: r[63:32], lo: r[31:0], cyc: exp_cycles(MDU_MULT, 32'h100)});
    drive_and_wait(MDU_MULT, 32'h7, 32'h100, 5, hs, ls, dc, bc, bd);
    e = sb.pop_front();
    checks++; if (hs !== e.hi) begin failures++; $display("FAIL busy_start_hi got=%h exp=%h", hs, e.hi); end
    checks++; if (ls !== e.lo) begin failures++; $display("FAIL busy_start_lo got=%h exp=%h", ls, e.lo); end
    checks++; if (dc !== e.cyc) begin failures++; $display("FAIL busy_start_done_cycle got=%0d exp=%0d", dc, e.cyc); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_not_queued got=%b exp=0", busy); end
  endtask

  task automatic test_flush();
    int dones;
    start = 1'b1; op = MDU_MTHI; a = 32'h1111;
    @(posedge clk); #1;
    op = MDU_MTLO; a = 32'h2222;
    @(posedge clk); #1;
    op = MDU_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy_c11 got=%b exp=0", busy); end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
    checks++; if (hi !== 32'h1111) begin failures++; $display("FAIL flush_hi got=%h exp=00001111", hi); end
    checks++; if (lo !== 32'h2222) begin failures++; $display("FAIL flush_lo got=%h exp=00002222", lo); end
    flush = 1'b1; start = 1'b1; op = MDU_MTHI; a = 32'h3333;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    checks++; if (hi !== 32'h3333) begin failures++; $display("FAIL flush_idle_mthi got=%h exp=00003333", hi); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = MDU_MULT; a = 32'h12345; b = 32'h777;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi, lo); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%b%b exp=00", busy, done); end
  endtask

  task automatic test_early_out();
    logic [2:0]  eo_op[3] = '{MDU_MULTU, MDU_MULTU, MDU_MULT};
    logic [31:0] eo_b[3]  = '{32'd1, 32'd0, 32'hFFFFFFFF};
    logic [63:0] r;
    logic [31:0] hs, ls;
    int dc, bc;
    logic bd;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      r = model(eo_op[i], 32'd9, eo_b[i]);
      sb.push_back('{hi: r[63:32], lo: r[31:0], cyc: exp_cycles(eo_op[i], eo_b[i])});
      drive_and_wait(eo_op[i], 32'd9, eo_b[i], 0, hs, ls, dc, bc, bd);
      e = sb.pop_front();
      checks++; if (hs !== e.hi) begin failures++; $display("FAIL early%0d_hi got=%h exp=%h", i, hs, e.hi); end
      checks++; if (ls !== e.lo) begin failures++; $display("FAIL early%0d_lo got=%h exp=%h", i, ls, e.lo); end
      checks++; if (dc !== e.cyc) begin failures++; $display("FAIL early%0d_done_cycle got=%0d exp=%0d", i, dc, e.cyc); end
      checks++; if (bc !== e.cyc - 1 || bd !== 1'b0) begin failures++; $display("FAIL early%0d_busy got=%0d/%b exp=%0d/0", i, bc, bd, e.cyc - 1); end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mt_back_to_back();
    test_start_while_busy();
    test_flush();
    test_reset_mid();
    test_early_out();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
